ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer in front of the single-port `RAM` block (enable, ReadWrite, 16-bit Address, 32-bit D_In/D_Out).
- Port 0 is the instruction-fetch requester (read-only); port 1 is the load/store requester (read/write).
- It grants one requester at a time with round-robin fairness and drives the RAM control pins for a fixed access window.
- It returns read data with a one-cycle acknowledge pulse.
- It is the only driver of the RAM pins in the CPU.

## Interface
- `ADDR_W`, 16, RAM address width.
- `DATA_W`, 32, RAM data width.
- `ACCESS_CYCLES`, 1, number of cycles enable is held per transaction (≥1).

- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_req`  in  1  fetch request, held until `p0_ack`.
- `p0_addr`  in  ADDR_W  fetch address, stable while `p0_req`.
- `p0_ack`  out  1  one-cycle completion pulse.
- `p1_req`  in  1  data request, held until `p1_ack`.
- `p1_we`  in  1  1 = write, 0 = read.
- `p1_addr`  in  ADDR_W  data address.
- `p1_wdata`  in  DATA_W  write data.
- `p1_ack`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  read data, valid in the `pX_ack` cycle.
- `ram_enable`  out  1  RAM enable.
- `ram_rw`  out  1  RAM ReadWrite: 0 = write, 1 = read (RAM convention).
- `ram_addr`  out  ADDR_W  RAM Address.
- `ram_din`  out  DATA_W  RAM D_In.
- `ram_dout`  in  DATA_W  RAM D_Out.

## Operation
FSM states: IDLE, ACCESS, RESP.

IDLE
- If no request is pending, stay.
- If one port requests, grant it.
- If both request, grant the port not granted last. `last_grant` resets to 1, so port 0 wins the first tie.
- On grant:
  - latch port id, address, we, wdata into internal registers;
  - load access counter with `ACCESS_CYCLES-1`;
  - go to ACCESS.

ACCESS
- Outputs:
  - `ram_enable`=1;
  - `ram_addr`/`ram_din` from latched values;
  - `ram_rw` = ~latched_we (port 0 always read).
- Counter decrements each cycle.
- At counter 0:
  - reads capture `ram_dout` into `rdata`;
  - writes leave `rdata` unchanged;
  - go to RESP.

RESP
- `ram_enable`=0.
- Assert the granted port's `ack` for exactly one cycle.
- Update `last_grant`.
- Go to IDLE.

Rules and boundary cases
- Requests are sampled only in IDLE. A request dropped during ACCESS still completes and still produces `ack`.
- A request still high in the cycle after `ack` is treated as a new transaction.
- Latched values are immune to requester input changes after grant.
- When `ram_enable`=0, `ram_addr`, `ram_din` and `ram_rw` hold their last values. This avoids glitching the RAM.
- Address width is passed straight through: no wrap or bounds check. Address 16'hFFFF is legal.

## Timing
- Reset values:
  - `p0_ack`=0, `p1_ack`=0, `ram_enable`=0, `ram_rw`=1;
  - `ram_addr`=0, `ram_din`=0, `rdata`=0;
  - state=IDLE, `last_grant`=1, counter=0.
- `rst` in any state returns to IDLE at the next edge. The in-flight access is abandoned, no `ack` is issued, and `ram_enable` is low in the following cycle.
- Request first seen high at edge k: `ram_enable` is high in cycles k+1 … k+ACCESS_CYCLES. `ack` and valid `rdata` occur in cycle k+ACCESS_CYCLES+1.
- Total latency is ACCESS_CYCLES+2 cycles, counting the request cycle through the ack cycle.
- Throughput: one transaction per ACCESS_CYCLES+2 cycles. A continuously waiting second requester is granted in the IDLE cycle immediately after the first port's `ack`.
- `p0_ack` and `p1_ack` are never high together.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W`/`DATA_W` defaults;
  - FSM state enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`);
  - constants `RAM_WRITE`=0 and `RAM_READ`=1.
- One natural sub-module: `rr_arb2`, a two-input round-robin grant with a `last_grant` register and an update strobe. The FSM and datapath latches stay in `ram_arbiter`.

## Test plan
- **Reset:** hold `rst` 3 cycles with both requests high → all outputs at reset values, no `ack`; first grant after release goes to port 0.
- **Single write then read:**
  - p1 writes 32'h0000_00AA to 16'd1 → `ram_enable` high 1 cycle with `ram_rw`=0, addr 1, din 32'hAA; `p1_ack` at request+2.
  - p0 then reads addr 1 (RAM model returns 32'hAA) → `rdata`=32'hAA with `p0_ack`.
- **Contention:** both request continuously for 4 transactions → grant order 0,1,0,1; each `ack` is a single cycle, never overlapping.
- **ACCESS_CYCLES=3:** p1 read of 16'hFFFF → enable high exactly 3 cycles; `rdata` equals the `ram_dout` of the third cycle; `ack` at request+4.
- **Input change after grant:** p1 changes addr from 5 to 9 during ACCESS → RAM still sees addr 5.
- **Dropped request:** p1 drops `req` mid-access → `ack` still issued once.
- **Reset mid-access:** `rst` asserted during ACCESS → no `ack`; `ram_enable`=0 next cycle; a subsequent p0 read completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared RAM-side definitions: default widths, arbiter FSM states and
// the RAM ReadWrite pin encoding.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // RAM ReadWrite pin: low writes, high reads
  localparam logic RAM_WRITE = 1'b0;
  localparam logic RAM_READ  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. On a tie the port not granted last wins;
// last_grant only moves when the owner strobes update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant;

  // Remember who was served last; resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (update) last_grant <= upd_id;
  end

  // Single requester wins outright; a tie goes to the other port
  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[1];
    if (req == 2'b11) gnt_id = ~last_grant;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer in front of the single-port RAM. Port 0 fetches
// (read-only), port 1 loads/stores. One transaction at a time:
// IDLE -> ACCESS (enable held ACCESS_CYCLES) -> RESP (one-cycle ack).
module ram_arbiter import mem_pkg::*; #(
  parameter int ADDR_W        = MEM_ADDR_W,
  parameter int DATA_W        = MEM_DATA_W,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lat_id;
  logic             gnt_valid, gnt_id;
  logic             grant;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({p1_req, p0_req}),
    .update    (state == ST_RESP),
    .upd_id    (lat_id),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Requests are only looked at while idle
  assign grant = (state == ST_IDLE) && gnt_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and RAM enable / ack decode
  always_comb begin
    state_nxt  = state;
    ram_enable = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    case (state)
      ST_IDLE:   if (gnt_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        ram_enable = 1'b1;
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        p0_ack    = ~lat_id;
        p1_ack    = lat_id;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted request straight into the RAM pin registers so
  // addr/din/rw stay put whenever enable is low; capture read data last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lat_id   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_rw   <= RAM_READ;
      rdata    <= '0;
    end else if (grant) begin
      lat_id <= gnt_id;
      cnt    <= CNT_W'(ACCESS_CYCLES - 1);
      if (gnt_id) begin
        ram_addr <= p1_addr;
        ram_din  <= p1_wdata;
        ram_rw   <= p1_we ? RAM_WRITE : RAM_READ;
      end else begin
        // fetch port never writes; din keeps its old value
        ram_addr <= p0_addr;
        ram_rw   <= RAM_READ;
      end
    end else if (state == ST_ACCESS) begin
      if (cnt == '0) begin
        if (ram_rw == RAM_READ) rdata <= ram_dout;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: DUT a (ACCESS_CYCLES=1) with a small RAM model, DUT b
// (ACCESS_CYCLES=3) with RAM data driven step by step.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;

  // DUT a
  logic        p0_req, p1_req, p1_we, p0_ack, p1_ack;
  logic [15:0] p0_addr, p1_addr, ram_addr;
  logic [31:0] p1_wdata, rdata, ram_din, ram_dout;
  logic        ram_enable, ram_rw;
  logic [31:0] mem [16];

  // DUT b
  logic        b_p0_req, b_p1_req, b_p1_we, b_p0_ack, b_p1_ack;
  logic [15:0] b_p0_addr, b_p1_addr, b_ram_addr;
  logic [31:0] b_p1_wdata, b_rdata, b_ram_din, b_ram_dout;
  logic        b_ram_enable, b_ram_rw;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(32), .ACCESS_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .ram_enable(ram_enable), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(32), .ACCESS_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_ack(b_p0_ack),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata), .p1_ack(b_p1_ack),
    .rdata(b_rdata), .ram_enable(b_ram_enable), .ram_rw(b_ram_rw),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
  );

  // RAM model for DUT a: async read, write on enable with rw low
  assign ram_dout = mem[ram_addr[3:0]];
  always @(posedge clk) begin
    if (ram_enable && !ram_rw) mem[ram_addr[3:0]] <= ram_din;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
    rst = 1'b1;
    p0_req = 0; p1_req = 0; p1_we = 0; p0_addr = 0; p1_addr = 0; p1_wdata = 0;
    b_p0_req = 0; b_p1_req = 0; b_p1_we = 0; b_p0_addr = 0; b_p1_addr = 0; b_p1_wdata = 0;
    b_ram_dout = 32'h0;

    // ---- reset held 3 cycles with both requests high
    p0_req = 1; p0_addr = 16'd3; p1_req = 1; p1_we = 0; p1_addr = 16'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_p0_ack", p0_ack, 0);
      chk("rst_p1_ack", p1_ack, 0);
      chk("rst_enable", ram_enable, 0);
    end
    chk("rst_rw", ram_rw, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;

    // first tie after reset goes to port 0
    tick();
    chk("first_en", ram_enable, 1);
    chk("first_addr", ram_addr, 16'd3);
    chk("first_rw", ram_rw, 1);
    tick();
    chk("first_p0_ack", p0_ack, 1);
    chk("first_p1_ack", p1_ack, 0);
    chk("first_rdata", rdata, 32'h1003);
    p0_req = 0;
    tick();                                    // IDLE, p1 still waiting
    chk("gap_en", ram_enable, 0);
    chk("gap_p0_ack", p0_ack, 0);
    tick();
    chk("p1wait_en", ram_enable, 1);
    chk("p1wait_addr", ram_addr, 16'd2);
    tick();
    chk("p1wait_ack", p1_ack, 1);
    chk("p1wait_rdata", rdata, 32'h1002);
    p1_req = 0;
    tick();

    // ---- p1 write 0xAA to addr 1
    p1_req = 1; p1_we = 1; p1_addr = 16'd1; p1_wdata = 32'h0000_00AA;
    tick();
    chk("wr_en", ram_enable, 1);
    chk("wr_rw", ram_rw, 0);
    chk("wr_addr", ram_addr, 16'd1);
    chk("wr_din", ram_din, 32'hAA);
    tick();
    chk("wr_en_off", ram_enable, 0);
    chk("wr_ack", p1_ack, 1);
    chk("wr_rdata_kept", rdata, 32'h1002);
    p1_req = 0; p1_we = 0;
    tick();
    chk("hold_addr", ram_addr, 16'd1);
    chk("hold_din", ram_din, 32'hAA);
    chk("hold_rw", ram_rw, 0);
    chk("idle_p1_ack", p1_ack, 0);

    // ---- p0 reads it back
    p0_req = 1; p0_addr = 16'd1;
    tick();
    chk("rd_rw", ram_rw, 1);
    chk("rd_addr", ram_addr, 16'd1);
    tick();
    chk("rd_ack", p0_ack, 1);
    chk("rd_rdata", rdata, 32'hAA);
    p0_req = 0;
    tick();

    // ---- input change after grant: addr 5 -> 9
    p1_req = 1; p1_addr = 16'd5;
    tick();
    chk("chg_addr", ram_addr, 16'd5);
    p1_addr = 16'd9;
    tick();
    chk("chg_ack", p1_ack, 1);
    chk("chg_addr_held", ram_addr, 16'd5);
    chk("chg_rdata", rdata, 32'h1005);
    p1_req = 0;
    tick();

    // ---- dropped request still acks once
    p1_req = 1; p1_addr = 16'd6;
    tick();
    chk("drop_en", ram_enable, 1);
    p1_req = 0;
    tick();
    chk("drop_ack", p1_ack, 1);
    chk("drop_rdata", rdata, 32'h1006);
    tick();
    chk("drop_ack_once", p1_ack, 0);
    chk("drop_en_off", ram_enable, 0);

    // ---- contention: last grant was port 1, so order 0,1,0,1
    p0_req = 1; p0_addr = 16'd4; p1_req = 1; p1_we = 0; p1_addr = 16'd7;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("ct_en", ram_enable, 1);
      chk("ct_addr", ram_addr, (t % 2 == 0) ? 16'd4 : 16'd7);
      tick();
      chk("ct_p0_ack", p0_ack, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("ct_p1_ack", p1_ack, (t % 2 == 0) ? 1'b0 : 1'b1);
      chk("ct_rdata", rdata, (t % 2 == 0) ? 32'h1004 : 32'h1007);
      if (t == 3) begin p0_req = 0; p1_req = 0; end
      tick();
      chk("ct_idle_p0", p0_ack, 0);
      chk("ct_idle_p1", p1_ack, 0);
    end

    // ---- reset mid-access
    p0_req = 1; p0_addr = 16'd8;
    tick();
    chk("mr_en", ram_enable, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_en_off", ram_enable, 0);
    chk("mr_no_ack", p0_ack, 0);
    chk("mr_addr_rst", ram_addr, 0);
    tick();
    chk("mr_re_en", ram_enable, 1);
    chk("mr_re_no_ack", p0_ack, 0);
    chk("mr_re_addr", ram_addr, 16'd8);
    tick();
    chk("mr_ack", p0_ack, 1);
    chk("mr_rdata", rdata, 32'h1008);
    p0_req = 0;
    tick();

    // ---- ACCESS_CYCLES=3: p1 read of 0xFFFF
    b_p1_req = 1; b_p1_we = 0; b_p1_addr = 16'hFFFF;
    tick();
    chk("b_en1", b_ram_enable, 1);
    chk("b_addr", b_ram_addr, 16'hFFFF);
    chk("b_rw", b_ram_rw, 1);
    b_ram_dout = 32'h111;
    tick();
    chk("b_en2", b_ram_enable, 1);
    chk("b_ack2", b_p1_ack, 0);
    b_ram_dout = 32'h222;
    tick();
    chk("b_en3", b_ram_enable, 1);
    chk("b_ack3", b_p1_ack, 0);
    b_ram_dout = 32'h333;
    tick();
    chk("b_en_off", b_ram_enable, 0);
    chk("b_ack", b_p1_ack, 1);
    chk("b_p0_ack", b_p0_ack, 0);
    chk("b_rdata", b_rdata, 32'h333);
    b_p1_req = 0;
    b_ram_dout = 32'h444;
    tick();
    chk("b_ack_once", b_p1_ack, 0);
    chk("b_rdata_hold", b_rdata, 32'h333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
